// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions the raw player buttons for the game logic. Each channel is
// synchronised through two flops, debounced with a stability counter and
// turned into a clean level plus one-cycle press/release pulses.
// Build option: define AUTO_REPEAT_EN to add per-channel auto-repeat press
// pulses while a button stays held. Without it, each debounced press gives
// exactly one press pulse.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BTN_ACTIVE_LOW  = 0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reject configurations the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_conditioner: invalid debounce/repeat configuration");
    end

    // Polarity is normalised before the synchroniser so everything after it
    // sees 1 = pressed; reset therefore loads 0 (the inactive level).
    logic [NUM_BTN-1:0] w_raw_pol;
    assign w_raw_pol = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    logic [NUM_BTN-1:0] r_s1;
    logic [NUM_BTN-1:0] r_s2;
    logic [NUM_BTN-1:0] r_level;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] r_release;
    logic [CNT_W-1:0]   r_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] w_repeat;

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= {NUM_BTN{1'b0}};
            r_s2 <= {NUM_BTN{1'b0}};
        end else begin
            r_s1 <= w_raw_pol;
            r_s2 <= r_s1;
        end
    end

    // A channel accepts its synced value once it has differed from the level
    // for DEBOUNCE_CYCLES consecutive samples.
    always_comb begin
        w_accept = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            w_accept[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == DB_MAX);
        end
    end

    // Stability counters and debounced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            r_level <= r_level ^ w_accept;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_s2[i] == r_level[i]) begin
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else if (w_accept[i]) begin
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    // r_rep_cnt counts cycles since the last press pulse; r_rep_phase selects
    // the initial delay (0) or the steady repeat period (1).
    logic [REP_W-1:0]   r_rep_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] r_rep_phase;

    // Repeat fires only while held and never on an edge where the level changes,
    // so a release cycle can never carry a repeat pulse.
    always_comb begin
        w_repeat = {NUM_BTN{1'b0}};
        for (int i = 0; i < NUM_BTN; i++) begin
            if (r_level[i] && !w_accept[i]) begin
                w_repeat[i] = (r_rep_cnt[i] == (r_rep_phase[i] ? PER_LAST : DLY_LAST));
            end else begin
                w_repeat[i] = 1'b0;
            end
        end
    end

    // Repeat timers: cleared while released and on every press pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rep_phase <= {NUM_BTN{1'b0}};
            for (int i = 0; i < NUM_BTN; i++) begin
                r_rep_cnt[i] <= {REP_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (!r_level[i] || w_accept[i]) begin
                    r_rep_cnt[i]   <= {REP_W{1'b0}};
                    r_rep_phase[i] <= 1'b0;
                end else if (w_repeat[i]) begin
                    r_rep_cnt[i]   <= {REP_W{1'b0}};
                    r_rep_phase[i] <= 1'b1;
                end else begin
                    r_rep_cnt[i]   <= r_rep_cnt[i] + REP_ONE;
                end
            end
        end
    end
`else
    assign w_repeat = {NUM_BTN{1'b0}};
`endif

    // Registered edge pulses, aligned with the cycle the new level is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press   <= {NUM_BTN{1'b0}};
            r_release <= {NUM_BTN{1'b0}};
        end else begin
            r_press   <= (w_accept & r_s2) | w_repeat;
            r_release <= w_accept & ~r_s2;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_press   = |r_press;

endmodule
